ta_cap_buf: RTL
===============

TA_CAP_BUF -- requirements
Module: ta_cap_buf

Interface
REQ-001 SHALL have parameter ADC0_1, default 56, width of one merged sample word (four 14-bit ADC samples).
REQ-002 SHALL have parameter AW, default 9, buffer address width; depth = 2^AW words.
REQ-003 SHALL have parameter LEN_W, default 16, width of the capture-length field.
REQ-004 SHALL have port clk62  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mem_reset  input  1  single-cycle arm/flush pulse from the capture sync stage.
REQ-007 SHALL have port cap_len  input  LEN_W  number of words per capture; sampled on mem_reset.
REQ-008 SHALL have port merge_data  input  ADC0_1  merged sample word from the ADC merge stage.
REQ-009 SHALL have port mereg_datv  input  1  merge_data valid, one word per high cycle.
REQ-010 SHALL have port rd_data  output  ADC0_1  head-of-buffer word.
REQ-011 SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-012 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-013 SHALL have port cap_done  output  1  capture of cap_len words complete.
REQ-014 SHALL have port cap_ovf  output  1  sticky: at least one word dropped because the buffer was full.
REQ-015 SHALL have port fill_lvl  output  AW+1  current stored word count.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, DONE.
REQ-017 IDLE: mereg_datv ignored; mem_reset -> FILL, or -> DONE when cap_len == 0.
REQ-018 FILL: each mereg_datv cycle increments the word counter; the word is written if not full, else dropped and cap_ovf set.
REQ-019 FILL -> DONE in the cycle the counter reaches the latched cap_len; the counter includes dropped words.
REQ-020 DONE: cap_done = 1; mereg_datv ignored; buffer still drains; stays until mem_reset or rst.
REQ-021 mem_reset in any state, including mid-FILL, SHALL flush the buffer, clear the counter, clear cap_ovf and cap_done, and latch cap_len, all in the same cycle.
REQ-022 mem_reset and mereg_datv in the same cycle: the word SHALL be discarded (flush wins).
REQ-023 Buffer SHALL be first-word-fall-through: a word written at edge N gives rd_valid = 1 with that word on rd_data after edge N.
REQ-024 A read transfer SHALL occur on each edge where rd_valid && rd_ready; rd_ready with rd_valid = 0 has no effect.
REQ-025 rd_data SHALL hold stable while rd_valid && !rd_ready.
REQ-026 Full SHALL be evaluated before the same-cycle read: a write while full is dropped even if a read occurs in the same cycle.
REQ-027 Simultaneous write and read when not full or empty SHALL leave fill_lvl unchanged.
REQ-028 Pointers SHALL wrap modulo 2^AW; full = (fill_lvl == 2^AW); empty = (fill_lvl == 0).
REQ-029 cap_done SHALL assert the cycle after the final counted word's edge.

Reset
REQ-030 rst SHALL force: state IDLE, pointers and counter 0, rd_valid 0, cap_done 0, cap_ovf 0, fill_lvl 0, rd_data 0.
REQ-031 Buffer RAM contents SHALL NOT be reset.

Structure
REQ-032 FSM state encoding and default parameter values SHALL live in the shared ta_pkg package.
REQ-033 Storage plus pointers SHALL be one sub-module, ta_sfifo (parameters ADC0_1, AW; FWFT; full/empty/level), instantiated once.
REQ-034 Capture FSM, counter, and cap_ovf SHALL reside in ta_cap_buf.

Verification
REQ-035 cap_len = 4, mem_reset, 4 datv words 0x1..0x4, rd_ready = 1 -> rd_data 0x1..0x4 in order, cap_done = 1 one cycle after the 4th word, a 5th datv ignored.
REQ-036 AW = 2, cap_len = 6, rd_ready = 0, 6 datv -> fill_lvl = 4, cap_ovf = 1, cap_done = 1, drain yields words 1..4.
REQ-037 mem_reset after 3 of 8 words -> fill_lvl = 0, cap_ovf = 0, the 3 words lost, new capture of 8 counts from 0.
REQ-038 cap_len = 0 with mem_reset -> cap_done = 1 on the next cycle, no words stored.
REQ-039 Random rd_ready backpressure over 100 words with AW = 9 -> output sequence equals input, rd_data stable while stalled, cap_ovf = 0.
REQ-040 rst asserted mid-FILL, asynchronously between edges -> all outputs reach their reset values immediately, state IDLE.

Source files
------------

// File: rtl/ta_pkg.sv
// Shared definitions for the capture buffer slice.
// Holds the capture FSM state encoding and default parameter values.
package ta_pkg;

  localparam int ADC0_1_DEF = 56;
  localparam int AW_DEF     = 9;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } cap_st_e;

endpackage

// File: rtl/ta_sfifo.sv
// First-word-fall-through synchronous FIFO holding capture words.
// Ports: clk, rst (async high), flush, wr_en/wr_data, rd_en,
//        rd_data/rd_valid (head word), full, level (stored count).
module ta_sfifo
  import ta_pkg::*;
#(
  parameter int ADC0_1 = ADC0_1_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADC0_1-1:0] wr_data,
  input  logic              rd_en,
  output logic [ADC0_1-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic [AW:0]       level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [ADC0_1-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  // Full/empty come from the level before this edge, so a write
  // while full is dropped even if a read happens in the same cycle.
  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_wr    = wr_en && !w_full && !flush;
  assign w_rd    = rd_en && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Head word is read straight from storage; forced to zero when
  // empty so rd_data is zero out of reset.
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid = !w_empty;
  assign full     = w_full;
  assign level    = r_level;

endmodule

// File: rtl/ta_cap_buf.sv
// Capture buffer: counts cap_len merged ADC words into a FWFT FIFO.
// Ports: clk62, rst, mem_reset/cap_len (arm), merge_data/mereg_datv
//        (in), rd_* (drain), cap_done, cap_ovf, fill_lvl.
module ta_cap_buf
  import ta_pkg::*;
#(
  parameter int ADC0_1 = ADC0_1_DEF,
  parameter int AW     = AW_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk62,
  input  logic              rst,
  input  logic              mem_reset,
  input  logic [LEN_W-1:0]  cap_len,
  input  logic [ADC0_1-1:0] merge_data,
  input  logic              mereg_datv,
  output logic [ADC0_1-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              cap_done,
  output logic              cap_ovf,
  output logic [AW:0]       fill_lvl
);

  cap_st_e          r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_done;
  logic             r_ovf;

  logic             w_full;
  logic             w_wr;
  logic             w_rd;
  logic [LEN_W-1:0] w_cnt_inc;

  // Only FILL accepts words; flush wins over a same-cycle word.
  assign w_wr      = (r_state == ST_FILL) && mereg_datv && !mem_reset;
  assign w_rd      = rd_valid && rd_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  ta_sfifo #(
    .ADC0_1 (ADC0_1),
    .AW     (AW)
  ) u_fifo (
    .clk      (clk62),
    .rst      (rst),
    .flush    (mem_reset),
    .wr_en    (w_wr),
    .wr_data  (merge_data),
    .rd_en    (w_rd),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (w_full),
    .level    (fill_lvl)
  );

  always_ff @(posedge clk62 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (mem_reset) begin
      r_cnt   <= '0;
      r_len   <= cap_len;
      r_ovf   <= 1'b0;
      r_done  <= (cap_len == '0);
      r_state <= (cap_len == '0) ? ST_DONE : ST_FILL;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          if (mereg_datv) begin
            // Dropped words still count toward the capture length.
            r_cnt <= w_cnt_inc;
            if (w_full) r_ovf <= 1'b1;
            if (w_cnt_inc == r_len) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_done <= 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cap_done = r_done;
  assign cap_ovf  = r_ovf;

endmodule
